// File: rtl/posit_stream_accumulate.sv
// Streaming per-packet posit accumulator (posit32, es=2) with an embedded posit adder.
// Define POSIT_ACC_PIPE_EN to register the adder result (ADD_WAIT cycle after each operand).

module positadd #(
    parameter int NBITS = 32,
    parameter int ES    = 2
) (
    input  logic             start,
    input  logic [NBITS-1:0] in1,
    input  logic [NBITS-1:0] in2,
    output logic [NBITS-1:0] result
);
    localparam int FW    = NBITS - 3 - ES;
    localparam int MW    = FW + 1;
    localparam int GB    = 3;
    localparam int AW    = MW + GB + 1;
    localparam int SW    = 12;
    localparam int VW    = 3 * NBITS;
    localparam int MAXSC = (NBITS - 2) * (1 << ES);
    localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};

    function automatic void decode(input logic [NBITS-1:0] p, output logic sgn,
                                   output logic signed [SW-1:0] sc, output logic [MW-1:0] m);
        logic [NBITS-1:0] a;
        logic [ES+FW-1:0] rem;
        logic r0, stop;
        int run, k;
        sgn = p[NBITS-1];
        a = sgn ? (~p + 1'b1) : p;
        r0 = a[NBITS-2];
        run = 0;
        stop = 1'b0;
        for (int i = NBITS - 2; i >= 0; i--) begin
            if (!stop && a[i] == r0) run++;
            else stop = 1'b1;
        end
        rem = (ES+FW)'((a << (run + 2)) >> (NBITS - ES - FW));
        k = r0 ? run - 1 : -run;
        sc = SW'(k * (1 << ES) + int'(rem[ES+FW-1 -: ES]));
        m = {1'b1, rem[FW-1:0]};
    endfunction

    // Regime/exponent/fraction are laid out left-aligned in a wide field, then
    // rounded to nearest-even; posits saturate at maxpos/minpos instead of overflowing.
    function automatic logic [NBITS-1:0] encode(input logic sgn, input logic signed [SW-1:0] sc,
                                                input logic [AW-1:0] frac);
        logic [VW-1:0] v;
        logic [NBITS-2:0] mag;
        logic guard, sticky;
        int k, len;
        v = '0;
        guard = 1'b0;
        sticky = 1'b0;
        if (sc > MAXSC) begin
            mag = '1;
        end else if (sc < -MAXSC) begin
            mag = {{(NBITS-2){1'b0}}, 1'b1};
        end else begin
            k = int'(sc) >>> ES;
            if (k >= 0) begin
                v = ~({VW{1'b1}} >> (k + 1));
                len = k + 2;
            end else begin
                v = {1'b1, {(VW-1){1'b0}}} >> (-k);
                len = 1 - k;
            end
            v = v | ({sc[ES-1:0], frac, {(VW-ES-AW){1'b0}}} >> len);
            mag = v[VW-1 -: NBITS-1];
            guard = v[VW-NBITS];
            sticky = |v[VW-NBITS-1:0];
            if (guard && (sticky || mag[0])) mag = mag + 1'b1;
        end
        return sgn ? (~{1'b0, mag} + 1'b1) : {1'b0, mag};
    endfunction

    logic sa, sb, sx, sy, st;
    logic signed [SW-1:0] sca, scb, scx, scy, scr;
    logic [MW-1:0] ma, mb, mx, my;
    logic [MW+GB-1:0] ext, sh, lost;
    logic [AW-1:0] opa, opb, fracr;
    logic [AW:0] sum;
    int diff, pos;

    always_comb begin
        result = '0;
        sh = '0;
        st = 1'b0;
        lost = '0;
        pos = 0;
        decode(in1, sa, sca, ma);
        decode(in2, sb, scb, mb);
        if ((scb > sca) || (scb == sca && mb > ma)) begin
            sx = sb; scx = scb; mx = mb;
            sy = sa; scy = sca; my = ma;
        end else begin
            sx = sa; scx = sca; mx = ma;
            sy = sb; scy = scb; my = mb;
        end
        diff = int'(scx - scy);
        ext = {my, {GB{1'b0}}};
        if (diff >= MW + GB) begin
            st = |my;
        end else begin
            sh = ext >> diff;
            lost = ext << (MW + GB - diff);
            st = |lost;
        end
        opa = {mx, {GB{1'b0}}, 1'b0};
        opb = {sh, st};
        sum = (sx == sy) ? ({1'b0, opa} + {1'b0, opb}) : ({1'b0, opa} - {1'b0, opb});
        for (int i = 0; i <= AW; i++) begin
            if (sum[i]) pos = i;
        end
        fracr = AW'(sum << (AW - pos));
        scr = SW'(int'(scx) + pos - (AW - 1));
        if (!start) result = '0;
        else if (in1 == NAR || in2 == NAR) result = NAR;
        else if (in1 == '0) result = in2;
        else if (in2 == '0) result = in1;
        else if (sum == '0) result = '0;
        else result = encode(sx, scr, fracr);
    end
endmodule

module posit_stream_accumulate #(
    parameter int NBITS      = 32,
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NBITS-1:0]      in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NBITS-1:0]      out_data,
    output logic                  out_inf,
    output logic                  out_zero,
    output logic [COUNT_BITS-1:0] out_count
);
    localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, HOLD, ADD_WAIT} state_t;

    state_t state, state_next;
    logic [NBITS-1:0] acc, acc_next, add_result;
    logic acc_inf, acc_inf_next, handshake;
    logic [COUNT_BITS-1:0] count, count_next;
`ifdef POSIT_ACC_PIPE_EN
    logic [NBITS-1:0] pend_data;
    logic [COUNT_BITS-1:0] pend_count;
    logic pend_inf, pend_last;
`endif

    assign handshake = in_valid & in_ready;

    positadd #(.NBITS(NBITS), .ES(2)) u_positadd (
        .start (handshake),
        .in1   (acc),
        .in2   (in_data),
        .result(add_result)
    );

    // Zero operands bypass the adder; NaR is sticky until the packet closes.
    always_comb begin
        acc_next = add_result;
        acc_inf_next = 1'b0;
        if (acc_inf || in_data == NAR) begin
            acc_next = NAR;
            acc_inf_next = 1'b1;
        end else if (acc == '0) begin
            acc_next = in_data;
        end else if (in_data == '0) begin
            acc_next = acc;
        end
        count_next = (&count) ? count : count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
`ifdef POSIT_ACC_PIPE_EN
                if (in_valid) state_next = ADD_WAIT;
`else
                if (in_valid && in_last) state_next = HOLD;
`endif
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ACCUM;
            end
            default: begin
`ifdef POSIT_ACC_PIPE_EN
                state_next = pend_last ? HOLD : ACCUM;
`else
                state_next = ACCUM;
`endif
            end
        endcase
    end

`ifdef POSIT_ACC_PIPE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            acc_inf <= 1'b0;
            count <= '0;
            pend_data <= '0;
            pend_inf <= 1'b0;
            pend_count <= '0;
            pend_last <= 1'b0;
            out_data <= '0;
            out_inf <= 1'b0;
            out_zero <= 1'b0;
            out_count <= '0;
        end else begin
            if (handshake) begin
                pend_data <= acc_next;
                pend_inf <= acc_inf_next;
                pend_count <= count_next;
                pend_last <= in_last;
            end
            if (state == ADD_WAIT) begin
                if (pend_last) begin
                    out_data <= pend_data;
                    out_inf <= pend_inf;
                    out_zero <= (pend_data == '0);
                    out_count <= pend_count;
                    acc <= '0;
                    acc_inf <= 1'b0;
                    count <= '0;
                end else begin
                    acc <= pend_data;
                    acc_inf <= pend_inf;
                    count <= pend_count;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            acc_inf <= 1'b0;
            count <= '0;
            out_data <= '0;
            out_inf <= 1'b0;
            out_zero <= 1'b0;
            out_count <= '0;
        end else if (handshake && !in_last) begin
            acc <= acc_next;
            acc_inf <= acc_inf_next;
            count <= count_next;
        end else if (handshake) begin
            out_data <= acc_next;
            out_inf <= acc_inf_next;
            out_zero <= (acc_next == '0);
            out_count <= count_next;
            acc <= '0;
            acc_inf <= 1'b0;
            count <= '0;
        end
    end
`endif
endmodule
